// File: rtl/hpu_pkg.sv
// hpu_pkg: shared definitions for the HPU control/status register block.
//   - byte offsets of the register map
//   - AXI-Lite slave FSM state encodings
//   - CTRL / STATUS bit positions
//   - register-select enum used by the decode / readback path
//   - apply_strb(): byte-lane merge for strobed writes
package hpu_pkg;

  localparam int unsigned CTRL_OFS    = 'h00;
  localparam int unsigned STATUS_OFS  = 'h04;
  localparam int unsigned ADDR_I_OFS  = 'h08;
  localparam int unsigned ADDR_J_OFS  = 'h0C;
  localparam int unsigned SCRATCH_OFS = 'h10;
  localparam int unsigned ITEM_OFS    = 'h14;
  localparam int unsigned VERSION_OFS = 'h18;

  localparam int CTRL_MATW = 0;
  localparam int CTRL_RUN  = 1;
  localparam int CTRL_LAST = 2;
  localparam int CTRL_IE   = 3;

  localparam int STAT_DONE = 0;
  localparam int STAT_MATW = 1;

  typedef enum logic [3:0] {
    INI = 4'b0000,
    AW  = 4'b0001,
    W   = 4'b0010,
    AWW = 4'b0011,
    AR1 = 4'b0100,
    AR2 = 4'b1000
  } axil_state_e;

  // SEL_NONE doubles as the index of the all-zero readback slot.
  typedef enum logic [2:0] {
    SEL_CTRL, SEL_STATUS, SEL_ADDR_I, SEL_ADDR_J,
    SEL_SCRATCH, SEL_ITEM, SEL_VERSION, SEL_NONE
  } reg_sel_e;

  function automatic logic [31:0] apply_strb(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[b*8 +: 8] = strb[b] ? wd[b*8 +: 8] : cur[b*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/hpu_axil_fsm.sv
// hpu_axil_fsm: AXI4-Lite slave handshake FSM for hpu_ctrl_regs.
//   clk, rst             : clock, async active-high reset
//   s_axi_aw*/w*/b*      : write address / data / response channels
//   s_axi_ar*/r*         : read address channel, rvalid/rready
//   reg_wr,wr_addr/data/strb : one-cycle write strobe, asserted on the
//                          cycle whose edge enters AWW (registers update there)
//   reg_rd,rd_addr       : one-cycle read strobe in AR1 (rdata captured there)
module hpu_axil_fsm
  import hpu_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              reg_wr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_strb,
  output logic              reg_rd,
  output logic [ADDR_W-1:0] rd_addr
);

  axil_state_e state, nxt;
  logic [ADDR_W-1:0] awaddr_q, araddr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INI;
    else     state <= nxt;
  end

  always_comb begin
    nxt           = state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_rvalid  = 1'b0;
    reg_wr        = 1'b0;
    reg_rd        = 1'b0;
    case (state)
      INI: begin
        s_axi_awready = 1'b1;
        s_axi_wready  = 1'b1;
        // A pending write wins arbitration; hold arready low so the losing
        // read sees no handshake and simply stays pending.
        s_axi_arready = !s_axi_awvalid && !s_axi_wvalid;
        if (s_axi_awvalid && s_axi_wvalid) begin
          nxt    = AWW;
          reg_wr = 1'b1;
        end
        else if (s_axi_awvalid) nxt = AW;
        else if (s_axi_wvalid)  nxt = W;
        else if (s_axi_arvalid) nxt = AR1;
      end
      AW: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) begin
          nxt    = AWW;
          reg_wr = 1'b1;
        end
      end
      W: begin
        s_axi_awready = 1'b1;
        if (s_axi_awvalid) begin
          nxt    = AWW;
          reg_wr = 1'b1;
        end
      end
      AWW: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) nxt = INI;
      end
      AR1: begin
        reg_rd = 1'b1;
        nxt    = AR2;
      end
      AR2: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) nxt = INI;
      end
      default: nxt = INI;
    endcase
  end

  // Half-arrived writes are parked here; the completing beat comes live.
  always_ff @(posedge clk) begin
    if (state == INI && s_axi_awvalid) awaddr_q <= s_axi_awaddr;
    if (state == INI && s_axi_wvalid) begin
      wdata_q <= s_axi_wdata;
      wstrb_q <= s_axi_wstrb;
    end
    if (s_axi_arvalid && s_axi_arready) araddr_q <= s_axi_araddr;
  end

  assign wr_addr = (state == AW) ? awaddr_q : s_axi_awaddr;
  assign wr_data = (state == W)  ? wdata_q  : s_axi_wdata;
  assign wr_strb = (state == W)  ? wstrb_q  : s_axi_wstrb;
  assign rd_addr = araddr_q;

endmodule

// File: rtl/hpu_ctrl_regs.sv
// hpu_ctrl_regs: AXI4-Lite control/status registers for the HPU top level.
//   clk, rst          : sole clock, async active-high reset
//   s_axi_*           : AXI4-Lite slave (bresp/rresp always OKAY)
//   mat_cnt           : item-memory write counter; matw self-clears when
//                       it reaches item_num
//   s_fin             : completion pulse, sets the sticky STATUS.done
//   run/matw/last     : CTRL bits
//   addr_i/addr_j     : loop bounds, item_num : item-memory fill count
//   irq               : done & ie, registered (HPU_IRQ_EN), else tied 0
// Build option: define HPU_IRQ_EN to enable CTRL.ie and the interrupt.
module hpu_ctrl_regs
  import hpu_pkg::*;
#(
  parameter int          ADDR_W   = 12,
  parameter int          IDX_W    = 20,
  parameter int          CNT_W    = 16,
  parameter int          I_RST    = 7,
  parameter int          J_RST    = 2,
  parameter int          ITEM_RST = 100,
  parameter logic [31:0] VERSION  = 32'h0001_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  input  logic [CNT_W-1:0]  mat_cnt,
  input  logic              s_fin,
  output logic              run,
  output logic              matw,
  output logic              last,
  output logic [IDX_W-1:0]  addr_i,
  output logic [IDX_W-1:0]  addr_j,
  output logic [CNT_W-1:0]  item_num,
  output logic              irq
);

  localparam int LO_W = ADDR_W - 2;

  logic              reg_wr, reg_rd;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [31:0]       wr_data, wr_val, scratch;
  logic [3:0]        wr_strb;
  logic              done, ie;
  reg_sel_e          wr_sel, rd_sel;
  logic [7:0][31:0]  regs_v;

  hpu_axil_fsm #(.ADDR_W(ADDR_W)) u_fsm (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .reg_wr(reg_wr), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .reg_rd(reg_rd), .rd_addr(rd_addr)
  );

  assign s_axi_bresp = 2'b00;
  assign s_axi_rresp = 2'b00;

  // Top two address bits must be zero; the rest must match an offset exactly.
  function automatic reg_sel_e decode(input logic [ADDR_W-1:0] a);
    reg_sel_e s;
    s = SEL_NONE;
    if (a[ADDR_W-1 -: 2] == 2'b00) begin
      case (a[LO_W-1:0])
        LO_W'(CTRL_OFS):    s = SEL_CTRL;
        LO_W'(STATUS_OFS):  s = SEL_STATUS;
        LO_W'(ADDR_I_OFS):  s = SEL_ADDR_I;
        LO_W'(ADDR_J_OFS):  s = SEL_ADDR_J;
        LO_W'(SCRATCH_OFS): s = SEL_SCRATCH;
        LO_W'(ITEM_OFS):    s = SEL_ITEM;
        LO_W'(VERSION_OFS): s = SEL_VERSION;
        default:            s = SEL_NONE;
      endcase
    end
    return s;
  endfunction

  assign wr_sel = decode(wr_addr);
  assign rd_sel = decode(rd_addr);

  // 32-bit view of every register; serves readback and strobe merging.
  always_comb begin
    regs_v                       = '0;
    regs_v[SEL_CTRL][CTRL_MATW]  = matw;
    regs_v[SEL_CTRL][CTRL_RUN]   = run;
    regs_v[SEL_CTRL][CTRL_LAST]  = last;
    regs_v[SEL_CTRL][CTRL_IE]    = ie;
    regs_v[SEL_STATUS][STAT_DONE] = done;
    regs_v[SEL_STATUS][STAT_MATW] = matw;
    regs_v[SEL_ADDR_I]           = 32'(addr_i);
    regs_v[SEL_ADDR_J]           = 32'(addr_j);
    regs_v[SEL_SCRATCH]          = scratch;
    regs_v[SEL_ITEM]             = 32'(item_num);
    regs_v[SEL_VERSION]          = VERSION;
  end

  assign wr_val = apply_strb(regs_v[wr_sel], wr_data, wr_strb);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run      <= 1'b0;
      matw     <= 1'b0;
      last     <= 1'b0;
      done     <= 1'b0;
      scratch  <= '0;
      addr_i   <= IDX_W'(I_RST);
      addr_j   <= IDX_W'(J_RST);
      item_num <= CNT_W'(ITEM_RST);
      s_axi_rdata <= '0;
`ifdef HPU_IRQ_EN
      ie       <= 1'b0;
`endif
    end
    else begin
      // Auto-clear first so a same-cycle CTRL write below overrides it.
      if (matw && mat_cnt == item_num) matw <= 1'b0;

      if (reg_wr) begin
        case (wr_sel)
          SEL_CTRL: if (wr_strb[0]) begin
            matw <= wr_data[CTRL_MATW];
            run  <= wr_data[CTRL_RUN];
            last <= wr_data[CTRL_LAST];
`ifdef HPU_IRQ_EN
            ie   <= wr_data[CTRL_IE];
`endif
          end
          SEL_ADDR_I:  addr_i   <= wr_val[IDX_W-1:0];
          SEL_ADDR_J:  addr_j   <= wr_val[IDX_W-1:0];
          SEL_SCRATCH: scratch  <= wr_val;
          SEL_ITEM:    item_num <= wr_val[CNT_W-1:0];
          default: ;
        endcase
      end

      // Sticky done: a completion pulse beats a coincident W1C.
      if (s_fin)
        done <= 1'b1;
      else if (reg_wr && wr_sel == SEL_STATUS && wr_strb[0] && wr_data[STAT_DONE])
        done <= 1'b0;

      if (reg_rd) s_axi_rdata <= regs_v[rd_sel];
    end
  end

`ifdef HPU_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else     irq <= done & ie;
  end
`else
  assign ie  = 1'b0;
  assign irq = 1'b0;
`endif

endmodule
